// File: rtl/y_input_conditioner.sv
// rtl/y_input_conditioner.sv - synchronise, debounce and edge-detect the raw Y input of the toggle-FF stage
module y_input_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int CNT_W       = 3,
    parameter int GLITCH_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                y_raw,
    input  logic                en,
    input  logic                glitch_clr,
    output logic                y,
    output logic                y_rise,
    output logic                y_fall,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    typedef enum logic {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s_out;
    state_t                 state, state_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic                   y_next, rise_next, fall_next;
    logic [GLITCH_W-1:0]    glitch_next;

    // Synchroniser keeps sampling even while disabled so re-enable sees a settled value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], y_raw};
        end
    end

    assign s_out = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= STABLE;
            cnt        <= '0;
            y          <= 1'b0;
            y_rise     <= 1'b0;
            y_fall     <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            y          <= y_next;
            y_rise     <= rise_next;
            y_fall     <= fall_next;
            glitch_cnt <= glitch_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        y_next      = y;
        rise_next   = 1'b0;
        fall_next   = 1'b0;
        glitch_next = glitch_cnt;

        if (!en) begin
            // Disabling discards any partial qualification
            state_next = STABLE;
            cnt_next   = '0;
        end else begin
            case (state)
                STABLE: begin
                    if (s_out != y) begin
                        state_next = QUALIFY;
                        cnt_next   = CNT_W'(1);
                    end
                end
                QUALIFY: begin
                    if (s_out == y) begin
                        state_next = STABLE;
                        cnt_next   = '0;
                        if (glitch_cnt != GLITCH_MAX) begin
                            glitch_next = glitch_cnt + 1'b1;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state_next = STABLE;
                        cnt_next   = '0;
                        y_next     = s_out;
                        rise_next  = s_out;
                        fall_next  = ~s_out;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end
            endcase
        end

        // Clear wins over a same-cycle abort increment
        if (glitch_clr) begin
            glitch_next = '0;
        end
    end

    assign busy = (state == QUALIFY);

endmodule
